// File: rtl/fmap_pkg.sv
// Shared definitions for the feature-map streaming path.
//   state_e  : controller states (IDLE, RUN, DRAIN)
//   requant8 : ReLU + rounding right shift + saturation of a signed 32-bit
//              accumulator word to a non-negative signed 8-bit pixel.
package fmap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int ACC_W = 32;
  localparam int PIX_W = 8;

  // 33-bit intermediate: the largest positive word plus the largest rounding
  // constant (2^30) still fits, so the add never wraps.
  function automatic logic signed [PIX_W-1:0] requant8(
    input logic signed [ACC_W-1:0] x,
    input int                      shift
  );
    logic [ACC_W:0] r;
    logic [ACC_W:0] q;
    r = x[ACC_W-1] ? '0 : {1'b0, x};
    if (shift > 0) r = r + ((ACC_W+1)'(1) << (shift - 1));
    q = r >> shift;
    return (q > (ACC_W+1)'(127)) ? 8'sd127 : signed'(q[PIX_W-1:0]);
  endfunction

endpackage

// File: rtl/fmap_streamer_fifo.sv
// stream_fifo: small synchronous FIFO holding requantized pixels.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   clr_i      : synchronous flush
//   push_i     : write din_i (caller guarantees space)
//   pop_i      : drop the head (caller guarantees non-empty)
//   dout_o     : current head
//   count_o    : occupancy
//   empty_o    : occupancy is zero
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= bump(wr_q);
      if (pop_i)  rd_q <= bump(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fmap_streamer.sv
// fmap_streamer: reads a MAPSIZE x MAPSIZE map of signed 32-bit accumulator
// words back from BRAM in raster order, requantizes each to a signed 8-bit
// pixel and emits it as a valid/ready stream.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a pass (sampled in IDLE only)
//   mem_rd_en       : BRAM read strobe
//   mem_rd_addr     : BRAM read address
//   mem_rd_data     : BRAM data, RD_LATENCY edges after the issuing edge
//   pixel_out       : requantized pixel (FIFO head, 0 when empty)
//   data_valid_out  : pixel_out valid
//   ready_in        : downstream accepts
//   busy            : pass in progress
//   all_done        : one-cycle pulse after the final transfer
module fmap_streamer
  import fmap_pkg::*;
#(
  parameter int MAPSIZE    = 28,
  parameter int RD_LATENCY = 1,
  parameter int SHIFT      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 mem_rd_en,
  output logic [$clog2(MAPSIZE*MAPSIZE)-1:0]   mem_rd_addr,
  input  logic signed [31:0]                   mem_rd_data,
  output logic signed [7:0]                    pixel_out,
  output logic                                 data_valid_out,
  input  logic                                 ready_in,
  output logic                                 busy,
  output logic                                 all_done
);

  localparam int N     = MAPSIZE * MAPSIZE;
  localparam int AW    = $clog2(N);
  localparam int DEPTH = RD_LATENCY + 2;
  localparam int CW    = $clog2(DEPTH + 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]         xfer_q, xfer_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] vpipe_q;
  logic                  all_done_q;

  logic [CW-1:0]         fifo_cnt;
  logic                  fifo_empty;
  logic [7:0]            fifo_dout;
  logic                  ret, xfer, last_rd, last_xfer, begin_pass, credit_ok;

  assign ret        = vpipe_q[RD_LATENCY-1];
  assign xfer       = data_valid_out && ready_in;
  assign last_rd    = mem_rd_en && (rd_cnt_q == AW'(N - 1));
  assign last_xfer  = xfer && (xfer_q == AW'(N - 1));
  assign begin_pass = (state_q == IDLE) && start;

  // Reads in flight plus pixels already buffered may never exceed the FIFO
  // depth, so every return has a slot even under full backpressure.
  assign credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CW+1)'(DEPTH);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_xfer) state_d = IDLE;
               else if (last_rd) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_rd_en = (state_q == RUN) && credit_ok;
    busy      = (state_q != IDLE);
  end

  // Counters: the read counter holds at N-1 so the address never wraps.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (begin_pass)                rd_cnt_d = '0;
    else if (mem_rd_en && !last_rd) rd_cnt_d = rd_cnt_q + 1'b1;

    xfer_d = xfer_q;
    if (begin_pass || last_xfer) xfer_d = '0;
    else if (xfer)               xfer_d = xfer_q + 1'b1;

    case ({mem_rd_en, ret})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q   <= '0;
      xfer_q     <= '0;
      inflight_q <= '0;
      vpipe_q    <= '0;
      all_done_q <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      xfer_q     <= xfer_d;
      inflight_q <= inflight_d;
      vpipe_q[0] <= mem_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vpipe_q[i] <= vpipe_q[i-1];
      all_done_q <= last_xfer;
    end
  end

  stream_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (begin_pass),
    .push_i  (ret),
    .pop_i   (xfer),
    .din_i   (requant8(mem_rd_data, SHIFT)),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  assign mem_rd_addr    = rd_cnt_q;
  assign data_valid_out = !fifo_empty;
  // Gate the head so the output reads 0 whenever nothing is buffered.
  assign pixel_out      = fifo_empty ? 8'sd0 : signed'(fifo_dout);
  assign all_done       = all_done_q;

endmodule

// File: tb/tb_fmap_streamer.sv
module tb_fmap_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change only 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- A: MAPSIZE=3, RD_LATENCY=1, SHIFT=8 ----------------
  logic               startA = 0, rdyA = 0, renA, vldA, busyA, doneA;
  logic [3:0]         addrA, apA;
  logic signed [31:0] dataA;
  logic signed [7:0]  pixA;
  logic signed [31:0] memA [9];
  always @(posedge clk) apA <= addrA;
  assign dataA = memA[apA];
  fmap_streamer #(.MAPSIZE(3), .RD_LATENCY(1), .SHIFT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(startA), .mem_rd_en(renA), .mem_rd_addr(addrA),
    .mem_rd_data(dataA), .pixel_out(pixA), .data_valid_out(vldA), .ready_in(rdyA),
    .busy(busyA), .all_done(doneA));

  // ---------------- B: MAPSIZE=4, RD_LATENCY=1, SHIFT=8 ----------------
  logic               startB = 0, rdyB = 0, renB, vldB, busyB, doneB;
  logic [3:0]         addrB, apB;
  logic signed [31:0] dataB;
  logic signed [7:0]  pixB;
  logic signed [31:0] memB [16];
  always @(posedge clk) apB <= addrB;
  assign dataB = memB[apB];
  fmap_streamer #(.MAPSIZE(4), .RD_LATENCY(1), .SHIFT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(startB), .mem_rd_en(renB), .mem_rd_addr(addrB),
    .mem_rd_data(dataB), .pixel_out(pixB), .data_valid_out(vldB), .ready_in(rdyB),
    .busy(busyB), .all_done(doneB));

  // ---------------- C: MAPSIZE=4, RD_LATENCY=3, SHIFT=8 ----------------
  logic               startC = 0, rdyC = 0, renC, vldC, busyC, doneC;
  logic [3:0]         addrC;
  logic [3:0]         apC [3];
  logic signed [31:0] dataC;
  logic signed [7:0]  pixC;
  logic signed [31:0] memC [16];
  always @(posedge clk) begin
    apC[0] <= addrC;
    apC[1] <= apC[0];
    apC[2] <= apC[1];
  end
  assign dataC = memC[apC[2]];
  fmap_streamer #(.MAPSIZE(4), .RD_LATENCY(3), .SHIFT(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(startC), .mem_rd_en(renC), .mem_rd_addr(addrC),
    .mem_rd_data(dataC), .pixel_out(pixC), .data_valid_out(vldC), .ready_in(rdyC),
    .busy(busyC), .all_done(doneC));

  // ---------------- D: MAPSIZE=2, RD_LATENCY=1, SHIFT=0 ----------------
  logic               startD = 0, rdyD = 0, renD, vldD, busyD, doneD;
  logic [1:0]         addrD, apD;
  logic signed [31:0] dataD;
  logic signed [7:0]  pixD;
  logic signed [31:0] memD [4];
  always @(posedge clk) apD <= addrD;
  assign dataD = memD[apD];
  fmap_streamer #(.MAPSIZE(2), .RD_LATENCY(1), .SHIFT(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(startD), .mem_rd_en(renD), .mem_rd_addr(addrD),
    .mem_rd_data(dataD), .pixel_out(pixD), .data_valid_out(vldD), .ready_in(rdyD),
    .busy(busyD), .all_done(doneD));

  // Transfer monitors: inputs are stable between posedge+1 and the next
  // posedge, so valid&&ready at the falling edge marks a transfer at the
  // following rising edge.
  int qA[$], qC[$], qD[$];
  int stall_pix = 0, stab_bad = 0, max_credit = 0;
  bit was_stalled = 0;
  always @(negedge clk) begin
    if (vldA && rdyA) qA.push_back(int'(pixA));
    if (vldD && rdyD) qD.push_back(int'(pixD));
    if (vldC && rdyC) qC.push_back(int'(pixC));
    if (was_stalled && (!vldC || int'(pixC) != stall_pix)) stab_bad++;
    was_stalled = vldC && !rdyC;
    stall_pix   = int'(pixC);
    if (int'(dut_c.inflight_q) + int'(dut_c.fifo_cnt) > max_credit)
      max_credit = int'(dut_c.inflight_q) + int'(dut_c.fifo_cnt);
  end

  typedef struct {
    logic signed [31:0] word;
    int                 exp;
  } vec_t;

  vec_t va [9];
  vec_t vd [4];
  bit   pat [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0] = '{-32'sd5, 0};        va[1] = '{32'sd0, 0};
    va[2] = '{32'sd127, 0};       va[3] = '{32'sd128, 1};
    va[4] = '{32'sd383, 1};       va[5] = '{32'sd384, 2};
    va[6] = '{32'sd40000, 127};   va[7] = '{32'sh7FFFFFFF, 127};
    va[8] = '{32'sh80000000, 0};
    vd[0] = '{32'sd5, 5};         vd[1] = '{32'sd200, 127};
    vd[2] = '{-32'sd1, 0};        vd[3] = '{32'sd0, 0};
    pat   = '{1, 0, 0, 1, 0, 1, 1, 0};
    for (int i = 0; i < 9; i++)  memA[i] = va[i].word;
    for (int i = 0; i < 4; i++)  memD[i] = vd[i].word;
    for (int i = 0; i < 16; i++) begin
      memB[i] = 32'(i) << 8;
      memC[i] = 32'(i) << 8;
    end

    // Reset state
    #2;
    chk("rst_rd_en", int'(renA), 0);
    chk("rst_addr", int'(addrA), 0);
    chk("rst_pix", int'(pixA), 0);
    chk("rst_vld", int'(vldA), 0);
    chk("rst_busy", int'(busyA), 0);
    chk("rst_done", int'(doneA), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", int'(busyC), 0);
    chk("idle_rd_en", int'(renC), 0);

    // Requant table, SHIFT=8
    rdyA = 1; startA = 1;
    tick();
    startA = 0;
    for (int i = 0; i < 100 && !doneA; i++) tick();
    chk("A_done", int'(doneA), 1);
    chk("A_count", qA.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("A_pix%0d", i), (i < qA.size()) ? qA[i] : -999, va[i].exp);

    // Requant table, SHIFT=0
    rdyD = 1; startD = 1;
    tick();
    startD = 0;
    for (int i = 0; i < 100 && !doneD; i++) tick();
    chk("D_done", int'(doneD), 1);
    chk("D_count", qD.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("D_pix%0d", i), (i < qD.size()) ? qD[i] : -999, vd[i].exp);

    // Throughput with start held high; the next edge is edge k
    rdyB = 1; startB = 1;
    tick();
    chk("B_rd_en_k", int'(renB), 1);
    chk("B_addr_k", int'(addrB), 0);
    chk("B_vld_k", int'(vldB), 0);
    tick();
    chk("B_vld_k1", int'(vldB), 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("B_vld%0d", i), int'(vldB), 1);
      chk($sformatf("B_pix%0d", i), int'(pixB), i);
      chk($sformatf("B_nodone%0d", i), int'(doneB), 0);
    end
    tick();
    chk("B_done", int'(doneB), 1);
    chk("B_busy_at_done", int'(busyB), 0);
    chk("B_vld_at_done", int'(vldB), 0);
    tick();
    chk("B_done_once", int'(doneB), 0);
    chk("B_restart_rd_en", int'(renB), 1);
    chk("B_restart_addr", int'(addrB), 0);
    chk("B_restart_busy", int'(busyB), 1);
    startB = 0;
    for (int i = 0; i < 100 && !doneB; i++) tick();
    chk("B_pass2_done", int'(doneB), 1);
    tick();

    // Backpressure with RD_LATENCY=3
    qC.delete();
    stab_bad = 0; max_credit = 0;
    startC = 1; rdyC = pat[0];
    tick();
    startC = 0;
    for (int c = 1; c < 300 && !doneC; c++) begin
      rdyC = pat[c % 8];
      tick();
    end
    rdyC = 0;
    chk("C_done", int'(doneC), 1);
    chk("C_count", qC.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("C_pix%0d", i), (i < qC.size()) ? qC[i] : -999, i);
    chk("C_head_stable_violations", stab_bad, 0);
    chk("C_credit_le5", int'(max_credit <= 5), 1);
    tick();

    // Mid-pass reset after 5 transfers
    qC.delete();
    rdyC = 1; startC = 1;
    tick();
    startC = 0;
    for (int i = 0; i < 100 && qC.size() < 5; i++) tick();
    chk("R_reached5", int'(qC.size() >= 5), 1);
    chk("R_busy_before", int'(busyC), 1);
    rst_n = 1'b0;
    #1;
    chk("R_rd_en", int'(renC), 0);
    chk("R_addr", int'(addrC), 0);
    chk("R_pix", int'(pixC), 0);
    chk("R_vld", int'(vldC), 0);
    chk("R_busy", int'(busyC), 0);
    chk("R_done", int'(doneC), 0);
    tick();
    rst_n = 1'b1;
    tick();
    qC.delete();
    startC = 1;
    tick();
    startC = 0;
    chk("R_first_rd_en", int'(renC), 1);
    chk("R_first_addr", int'(addrC), 0);
    for (int i = 0; i < 100 && !doneC; i++) tick();
    chk("R_done_after", int'(doneC), 1);
    chk("R_count", qC.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("R_pix%0d", i), (i < qC.size()) ? qC[i] : -999, i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
